// File: rtl/range_counter_gen.sv
// Up/down counter confined to a runtime-programmable range [lo,hi] with wrap/saturate/bounce modes.
// Optional event statistics counter enabled by defining RANGE_CNT_WRAP_STAT_EN.
module range_counter_gen #(
  parameter int WIDTH  = 8,
  parameter int DEF_LO = 10,
  parameter int DEF_HI = 100,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              cfg_we,
  input  logic [WIDTH-1:0]  cfg_lo,
  input  logic [WIDTH-1:0]  cfg_hi,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              at_lo,
  output logic              at_hi,
  output logic              dir,
  output logic              cfg_err
`ifdef RANGE_CNT_WRAP_STAT_EN
  ,
  output logic [15:0]       evt_cnt
`endif
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] LO_INIT = WIDTH'(DEF_LO);
  localparam logic [WIDTH-1:0] HI_INIT = WIDTH'(DEF_HI);

  generate
    if (DEF_LO > DEF_HI || DEF_LO < 0 || longint'(DEF_HI) >= (longint'(1) << WIDTH)) begin : g_bad_params
      $error("range_counter_gen: need 0 <= DEF_LO <= DEF_HI < 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_r, lo_r, hi_r;
  logic             dir_r, tc_r, cfg_err_r;
  logic [WIDTH-1:0] count_nxt, lo_nxt, hi_nxt;
  logic             dir_nxt, tc_nxt, cfg_err_nxt, evt;
  logic [WIDTH:0]   step_ext, sum_up, lo_plus;
  logic             going_up, is_wrap, is_bounce;
  mode_t            mode_e;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Arithmetic is one bit wider than the counter so an overshoot past 2**WIDTH-1 is still seen as an event.
  assign mode_e    = mode_t'(mode);
  assign is_bounce = (mode_e == MODE_BOUNCE);
  assign is_wrap   = (mode_e == MODE_WRAP) || (mode_e == MODE_RSVD);
  assign going_up  = is_bounce ? dir_r : up_dn;
  assign step_ext  = (WIDTH+1)'(step);
  assign sum_up    = {1'b0, count_r} + step_ext;
  assign lo_plus   = {1'b0, lo_r} + step_ext;

  always_comb begin
    count_nxt   = count_r;
    lo_nxt      = lo_r;
    hi_nxt      = hi_r;
    dir_nxt     = dir_r;
    cfg_err_nxt = 1'b0;
    evt         = 1'b0;
    if (cfg_we) begin
      if (cfg_lo <= cfg_hi) begin
        lo_nxt    = cfg_lo;
        hi_nxt    = cfg_hi;
        count_nxt = clamp(count_r, cfg_lo, cfg_hi);
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end else if (load) begin
      count_nxt = clamp(load_val, lo_r, hi_r);
    end else if (en && step != '0) begin
      if (going_up) begin
        if (sum_up > {1'b0, hi_r}) begin
          evt       = 1'b1;
          count_nxt = is_wrap ? lo_r : hi_r;
          if (is_bounce) dir_nxt = 1'b0;
        end else begin
          count_nxt = sum_up[WIDTH-1:0];
        end
      end else begin
        if ({1'b0, count_r} < lo_plus) begin
          evt       = 1'b1;
          count_nxt = is_wrap ? hi_r : lo_r;
          if (is_bounce) dir_nxt = 1'b1;
        end else begin
          count_nxt = count_r - step_ext[WIDTH-1:0];
        end
      end
    end
    tc_nxt = evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= LO_INIT;
      lo_r      <= LO_INIT;
      hi_r      <= HI_INIT;
      dir_r     <= 1'b1;
      tc_r      <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      count_r   <= count_nxt;
      lo_r      <= lo_nxt;
      hi_r      <= hi_nxt;
      dir_r     <= dir_nxt;
      tc_r      <= tc_nxt;
      cfg_err_r <= cfg_err_nxt;
    end
  end

`ifdef RANGE_CNT_WRAP_STAT_EN
  logic [15:0] evt_cnt_r;
  logic        cfg_ok;

  assign cfg_ok = cfg_we && (cfg_lo <= cfg_hi);

  always_ff @(posedge clk) begin
    if (rst || cfg_ok) begin
      evt_cnt_r <= '0;
    end else if (evt && evt_cnt_r != 16'hFFFF) begin
      evt_cnt_r <= evt_cnt_r + 16'd1;
    end
  end

  assign evt_cnt = evt_cnt_r;
`endif

  assign count   = count_r;
  assign tc      = tc_r;
  assign dir     = dir_r;
  assign cfg_err = cfg_err_r;
  assign at_lo   = (count_r == lo_r);
  assign at_hi   = (count_r == hi_r);

endmodule

// File: tb/tb_range_counter_gen.sv
// Directed self-checking bench for range_counter_gen (default parameters).
// Also exercises evt_cnt when RANGE_CNT_WRAP_STAT_EN is defined.
module tb_range_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, cfg_we;
  logic [1:0] mode;
  logic [3:0] step;
  logic [7:0] load_val, cfg_lo, cfg_hi;
  logic [7:0] count;
  logic       tc, at_lo, at_hi, dir, cfg_err;
`ifdef RANGE_CNT_WRAP_STAT_EN
  logic [15:0] evt_cnt;
`endif

  int total_checks = 0;
  int pass_checks  = 0;

  range_counter_gen #(.WIDTH(8), .DEF_LO(10), .DEF_HI(100), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .step(step),
    .load(load), .load_val(load_val), .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .count(count), .tc(tc), .at_lo(at_lo), .at_hi(at_hi), .dir(dir), .cfg_err(cfg_err)
`ifdef RANGE_CNT_WRAP_STAT_EN
    , .evt_cnt(evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are sampled 1ns after the last edge.
  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) pass_checks++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 2'b00; step = 4'd1;
    load = 1'b0; load_val = '0; cfg_we = 1'b0; cfg_lo = '0; cfg_hi = '0;
    apply_stimulus(2);
    check_output("reset_count", 32'(count), 32'd10);
    check_output("reset_at_lo", 32'(at_lo), 32'd1);
    check_output("reset_at_hi", 32'(at_hi), 32'd0);
    check_output("reset_dir", 32'(dir), 32'd1);
    check_output("reset_tc", 32'(tc), 32'd0);
    check_output("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;

    $display("[TB] wrap up step 1");
    en = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      apply_stimulus(1);
      check_output("wrap_ramp", 32'(count), 32'(10 + i));
    end
    check_output("wrap_at_hi", 32'(at_hi), 32'd1);
    check_output("wrap_pre_tc", 32'(tc), 32'd0);
    apply_stimulus(1);
    check_output("wrap_to_lo", 32'(count), 32'd10);
    check_output("wrap_tc", 32'(tc), 32'd1);
    apply_stimulus(1);
    check_output("wrap_after", 32'(count), 32'd11);
    check_output("wrap_tc_clear", 32'(tc), 32'd0);

    $display("[TB] step 0 holds");
    step = 4'd0;
    apply_stimulus(2);
    check_output("hold_count", 32'(count), 32'd11);
    check_output("hold_tc", 32'(tc), 32'd0);

    $display("[TB] saturate down step 3");
    en = 1'b0; load = 1'b1; load_val = 8'd16;
    apply_stimulus(1);
    check_output("sat_load", 32'(count), 32'd16);
    load = 1'b0; en = 1'b1; mode = 2'b01; up_dn = 1'b0; step = 4'd3;
    apply_stimulus(1);
    check_output("sat_13", 32'(count), 32'd13);
    check_output("sat_13_tc", 32'(tc), 32'd0);
    apply_stimulus(1);
    check_output("sat_10", 32'(count), 32'd10);
    check_output("sat_10_tc", 32'(tc), 32'd0);
    apply_stimulus(1);
    check_output("sat_pinned", 32'(count), 32'd10);
    check_output("sat_pinned_tc", 32'(tc), 32'd1);
    check_output("sat_at_lo", 32'(at_lo), 32'd1);
    apply_stimulus(1);
    check_output("sat_pinned_tc2", 32'(tc), 32'd1);

    $display("[TB] bounce step 5");
    en = 1'b0; load = 1'b1; load_val = 8'd95;
    apply_stimulus(1);
    load = 1'b0; en = 1'b1; mode = 2'b10; step = 4'd5; up_dn = 1'b0;
    apply_stimulus(1);
    check_output("bnc_100", 32'(count), 32'd100);
    check_output("bnc_100_dir", 32'(dir), 32'd1);
    up_dn = 1'b1;
    apply_stimulus(1);
    check_output("bnc_turn", 32'(count), 32'd100);
    check_output("bnc_turn_dir", 32'(dir), 32'd0);
    check_output("bnc_turn_tc", 32'(tc), 32'd1);
    up_dn = 1'b0;
    apply_stimulus(1);
    check_output("bnc_95", 32'(count), 32'd95);
    check_output("bnc_95_tc", 32'(tc), 32'd0);
    up_dn = 1'b1;
    apply_stimulus(1);
    check_output("bnc_90", 32'(count), 32'd90);

    $display("[TB] bound programming");
    en = 1'b0; mode = 2'b00; load = 1'b1; load_val = 8'd3;
    apply_stimulus(1);
    check_output("load_clamp_lo", 32'(count), 32'd10);
    cfg_we = 1'b1; cfg_lo = 8'd50; cfg_hi = 8'd60; load_val = 8'd55;
    apply_stimulus(1);
    check_output("cfg_clamp", 32'(count), 32'd50);
    check_output("cfg_at_lo", 32'(at_lo), 32'd1);
    check_output("cfg_no_err", 32'(cfg_err), 32'd0);
    load = 1'b0; cfg_lo = 8'd70; cfg_hi = 8'd60;
    apply_stimulus(1);
    check_output("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check_output("cfg_err_count", 32'(count), 32'd50);
    check_output("cfg_err_lo_kept", 32'(at_lo), 32'd1);
    cfg_we = 1'b0;
    apply_stimulus(1);
    check_output("cfg_err_clear", 32'(cfg_err), 32'd0);

    $display("[TB] clamped load and reset");
    load = 1'b1; load_val = 8'd200;
    apply_stimulus(1);
    check_output("load_hi", 32'(count), 32'd60);
    check_output("load_at_hi", 32'(at_hi), 32'd1);
    load_val = 8'd3;
    apply_stimulus(1);
    check_output("load_lo", 32'(count), 32'd50);
    check_output("dir_retained", 32'(dir), 32'd0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1; step = 4'd1;
    apply_stimulus(1);
    check_output("run_51", 32'(count), 32'd51);
    rst = 1'b1;
    apply_stimulus(1);
    rst = 1'b0;
    check_output("rst_count", 32'(count), 32'd10);
    check_output("rst_dir", 32'(dir), 32'd1);
    check_output("rst_at_lo", 32'(at_lo), 32'd1);
    en = 1'b0; load = 1'b1; load_val = 8'd100;
    apply_stimulus(1);
    check_output("rst_hi_bound", 32'(at_hi), 32'd1);
    load = 1'b0;

    $display("[TB] full-width range");
    cfg_we = 1'b1; cfg_lo = 8'd10; cfg_hi = 8'd255;
    apply_stimulus(1);
    cfg_we = 1'b0; load = 1'b1; load_val = 8'd250;
    apply_stimulus(1);
    check_output("wide_load", 32'(count), 32'd250);
    load = 1'b0; en = 1'b1; mode = 2'b00; up_dn = 1'b1; step = 4'd15;
    apply_stimulus(1);
    check_output("wide_wrap", 32'(count), 32'd10);
    check_output("wide_wrap_tc", 32'(tc), 32'd1);
`ifdef RANGE_CNT_WRAP_STAT_EN
    check_output("evt_cnt_1", 32'(evt_cnt), 32'd1);
`endif
    up_dn = 1'b0;
    apply_stimulus(1);
    check_output("wide_wrap_dn", 32'(count), 32'd255);
    check_output("wide_wrap_dn_tc", 32'(tc), 32'd1);
`ifdef RANGE_CNT_WRAP_STAT_EN
    check_output("evt_cnt_2", 32'(evt_cnt), 32'd2);
`endif
    mode = 2'b11; up_dn = 1'b1; step = 4'd1;
    apply_stimulus(1);
    check_output("rsvd_wrap", 32'(count), 32'd10);
    en = 1'b0;
    apply_stimulus(1);
    check_output("idle_tc", 32'(tc), 32'd0);

    $display("[TB] %0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
